// File: rtl/soc_mem_ctl.sv
// soc_mem_ctl: parametrised single-port SoC memory wrapper.
// Byte-lane writes and pipelined reads (1 or 2 cycle latency) behind a
// valid/ready request port. After reset the whole array can optionally be
// zero-filled, one word per cycle. Addresses at or beyond DEPTH are flagged
// on err_oob: an out-of-range write is dropped and an out-of-range read
// returns zero.
module soc_mem_ctl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_W/8-1:0]   req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  err_oob,
  output logic                  init_busy
);

  localparam int NB = DATA_W / 8;
  // One extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                fill_we;
  logic                ready_q, busy_q;

  logic                accept, is_wr, in_range, rd_acc, ram_re;
  logic [NB-1:0]       ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;

  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   ram_q;

  logic                rd_v1, rd_oob1, wr_oob1, zero_q;
  logic [DATA_W-1:0]   rd_data1;

  // State register, fill counter and the registered ready/busy flags.
  // ready/busy follow the next state so they are 0/INIT_CLEAR during reset
  // and change on the same edge as the state.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (INIT_CLEAR != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_RUN);
      busy_q  <= (state_d == ST_INIT);
    end
  end

  // Next-state logic: INIT writes zero to cnt each cycle and leaves on the
  // edge that writes the last word; RUN is only left through reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign req_ready = ready_q;
  assign init_busy = busy_q;

  assign accept   = req_valid && ready_q;
  assign is_wr    = |req_we;
  assign in_range = ({1'b0, req_addr} < DEPTH_L);
  assign rd_acc   = accept && !is_wr;
  assign ram_re   = rd_acc && in_range;

  // Single RAM port shared by the zero-fill and the request path; the two
  // never overlap because requests are refused while filling.
  always_comb begin
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    ram_we    = '0;
    if (fill_we) begin
      ram_addr  = cnt_q;
      ram_wdata = '0;
      ram_we    = '1;
    end else if (accept && in_range) begin
      ram_we = req_we;
    end
  end

  // Byte-write RAM with a registered read, no reset, so it maps to block RAM.
  always_ff @(posedge clka) begin
    for (int i = 0; i < NB; i++) begin
      if (ram_we[i]) begin
        ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_re) begin
      ram_q <= ram[ram_addr];
    end
  end

  // First read stage: response valid, out-of-range flags, and a sticky
  // zero-select that forces the data to 0 for out-of-range reads and after
  // reset while letting the RAM output hold between reads.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rd_v1   <= 1'b0;
      rd_oob1 <= 1'b0;
      wr_oob1 <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      rd_v1   <= rd_acc;
      rd_oob1 <= rd_acc && !in_range;
      wr_oob1 <= accept && is_wr && !in_range;
      if (rd_acc) begin
        zero_q <= !in_range;
      end
    end
  end

  assign rd_data1 = zero_q ? '0 : ram_q;

  if (RD_LAT == 2) begin : g_lat2
    logic              rd_v2, rd_oob2;
    logic [DATA_W-1:0] rdata_q;

    // Output register stage; data only loads on a valid response so it
    // holds its last value otherwise.
    always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
        rd_v2   <= 1'b0;
        rd_oob2 <= 1'b0;
        rdata_q <= '0;
      end else begin
        rd_v2   <= rd_v1;
        rd_oob2 <= rd_oob1;
        if (rd_v1) begin
          rdata_q <= rd_data1;
        end
      end
    end

    assign rsp_valid = rd_v2;
    assign rsp_rdata = rdata_q;
    assign err_oob   = rd_oob2 | wr_oob1;
  end else begin : g_lat1
    assign rsp_valid = rd_v1;
    assign rsp_rdata = rd_data1;
    assign err_oob   = rd_oob1 | wr_oob1;
  end

endmodule
